dtt_xbar_rr_scheduler: RTL

//  Per-output round-robin scheduler for the DTT crossbar switch datapath. Decides which input

---
 rtl/dtt_xbar_rr_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dtt_xbar_rr_scheduler.sv
// Per-output round-robin scheduler for the crossbar datapath.
// Each output port runs its own IDLE/LOCKED FSM. An output keeps its owner for a whole
// packet, passes that output's ready back to the owner, and releases the owner after
// the last beat or after TIMEOUT consecutive owner-idle cycles.
//
//   state  | meaning
//   IDLE   | output unowned; arbitrates round-robin among eligible inputs
//   LOCKED | output owned by owner_q; beats flow while out_ready_i is high
module dtt_xbar_rr_scheduler #(
    parameter int N_IN    = 4,
    parameter int N_OUT   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [N_IN-1:0]               req_valid_i,
    input  logic [N_IN*$clog2(N_OUT)-1:0] req_dest_i,
    input  logic [N_IN-1:0]               req_last_i,
    output logic [N_IN-1:0]               req_ready_o,
    input  logic [N_OUT-1:0]              out_ready_i,
    output logic [N_OUT*$clog2(N_IN)-1:0] out_sel_o,
    output logic [N_OUT-1:0]              out_sel_valid_o,
    output logic [N_OUT-1:0]              timeout_pulse_o
);
    localparam int DW    = $clog2(N_OUT);
    localparam int SW    = $clog2(N_IN);
    localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    // Counter value at which one more idle cycle completes the timeout.
    localparam logic [CW-1:0] TO_LAST = CW'(TO_M1);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

    state_e          state_q    [N_OUT];
    state_e          state_d    [N_OUT];
    logic [SW-1:0]   owner_q    [N_OUT];
    logic [SW-1:0]   owner_d    [N_OUT];
    logic [SW-1:0]   rr_ptr_q   [N_OUT];
    logic [SW-1:0]   rr_ptr_d   [N_OUT];
    logic [CW-1:0]   idle_cnt_q [N_OUT];
    logic [CW-1:0]   idle_cnt_d [N_OUT];
    logic [N_OUT-1:0] pulse_q;
    logic [N_OUT-1:0] pulse_d;
    logic [N_IN-1:0]  owns;

    // State register: all per-output state, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int j = 0; j < N_OUT; j++) begin
                state_q[j]    <= IDLE;
                owner_q[j]    <= '0;
                rr_ptr_q[j]   <= '0;
                idle_cnt_q[j] <= '0;
            end
            pulse_q <= '0;
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                state_q[j]    <= state_d[j];
                owner_q[j]    <= owner_d[j];
                rr_ptr_q[j]   <= rr_ptr_d[j];
                idle_cnt_q[j] <= idle_cnt_d[j];
            end
            pulse_q <= pulse_d;
        end
    end

    // Inputs that currently own some output; they may not win another one.
    always_comb begin
        owns = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (state_q[j] == LOCKED) owns[owner_q[j]] = 1'b1;
        end
    end

    // Next-state logic: round-robin grant in IDLE, packet / timeout release in LOCKED.
    always_comb begin
        logic found;
        logic rel;
        int   cand;
        int   own;
        found   = 1'b0;
        rel     = 1'b0;
        cand    = 0;
        own     = 0;
        pulse_d = '0;
        for (int j = 0; j < N_OUT; j++) begin
            state_d[j]    = state_q[j];
            owner_d[j]    = owner_q[j];
            rr_ptr_d[j]   = rr_ptr_q[j];
            idle_cnt_d[j] = idle_cnt_q[j];
            found         = 1'b0;
            rel           = 1'b0;
            own           = int'(owner_q[j]);
            case (state_q[j])
                IDLE: begin
                    for (int k = 0; k < N_IN; k++) begin
                        cand = (int'(rr_ptr_q[j]) + k) % N_IN;
                        if (!found && req_valid_i[cand] && !owns[cand] &&
                            (req_dest_i[cand*DW +: DW] == DW'(j))) begin
                            found      = 1'b1;
                            owner_d[j] = SW'(cand);
                        end
                    end
                    if (found) begin
                        state_d[j]    = LOCKED;
                        idle_cnt_d[j] = '0;
                    end
                end
                LOCKED: begin
                    if (req_valid_i[own]) begin
                        idle_cnt_d[j] = '0;
                        if (out_ready_i[j] && req_last_i[own]) rel = 1'b1;
                    end else if (out_ready_i[j] && (TIMEOUT != 0)) begin
                        // Backpressured cycles do not count as owner-idle.
                        if (idle_cnt_q[j] == TO_LAST) begin
                            rel        = 1'b1;
                            pulse_d[j] = 1'b1;
                        end else begin
                            idle_cnt_d[j] = idle_cnt_q[j] + 1'b1;
                        end
                    end
                    if (rel) begin
                        state_d[j]    = IDLE;
                        owner_d[j]    = '0;
                        idle_cnt_d[j] = '0;
                        rr_ptr_d[j]   = (own == N_IN - 1) ? '0 : owner_q[j] + 1'b1;
                    end
                end
                default: state_d[j] = IDLE;
            endcase
        end
    end

    // Outputs: selects straight from registers, ready routed from the owned output.
    always_comb begin
        req_ready_o     = '0;
        out_sel_o       = '0;
        out_sel_valid_o = '0;
        timeout_pulse_o = pulse_q;
        for (int j = 0; j < N_OUT; j++) begin
            out_sel_o[j*SW +: SW] = owner_q[j];
            out_sel_valid_o[j]    = (state_q[j] == LOCKED);
            if ((state_q[j] == LOCKED) && out_ready_i[j]) req_ready_o[owner_q[j]] = 1'b1;
        end
    end

endmodule
